multicycle_controller: RTL

- Multi-cycle sequencer for the RISC-V datapath: register file, ALU, operand/writeback muxes and data memory.
- Owns the instruction register and steps each instruction through FETCH, DECODE, EXEC, MEM and WB.
- Handshakes with instruction and data memory (req/ready), drives all datapath control strobes, and retires one instruction at a time.
- Supported instructions: lw, sw, add, sub, addi, ecall (halt). Anything else traps.

---
 rtl/multicycle_controller.sv | 234 +++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_controller.sv
// Multi-cycle RISC-V sequencer: owns the IR, steps FETCH/DECODE/EXEC/MEM/WB,
// handshakes with instruction/data memory and drives registered datapath strobes.
module multicycle_controller #(
  parameter int WORDSIZE         = 64,
  parameter int INSTRUCTION_SIZE = 32
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  output logic                        im_req,
  input  logic                        im_ready,
  input  logic [INSTRUCTION_SIZE-1:0] im_rdata,
  output logic                        dm_req,
  output logic                        dm_we,
  input  logic                        dm_ready,
  output logic [INSTRUCTION_SIZE-1:0] ir,
  output logic                        pc_en,
  output logic [4:0]                  rf_addr_a,
  output logic [4:0]                  rf_addr_b,
  output logic [4:0]                  rf_write_addr,
  output logic                        rf_write_en,
  output logic [WORDSIZE-1:0]         immediate,
  output logic                        mux_0_sel,
  output logic                        mux_1_sel,
  output logic                        mux_2_sel,
  output logic [2:0]                  alu_operation,
  output logic                        halted,
  output logic                        illegal,
  output logic [31:0]                 instr_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  function automatic logic [WORDSIZE-1:0] sext12(input logic signed [11:0] v);
    return {{(WORDSIZE-12){v[11]}}, v};
  endfunction

  state_t                      state_q, state_d;
  logic                        im_req_q, im_req_d;
  logic                        dm_req_q, dm_req_d;
  logic                        dm_we_q, dm_we_d;
  logic [INSTRUCTION_SIZE-1:0] ir_q, ir_d;
  logic                        pc_en_q, pc_en_d;
  logic [4:0]                  rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
  logic                        rf_we_q, rf_we_d;
  logic [WORDSIZE-1:0]         imm_q, imm_d;
  logic                        mux1_q, mux1_d, mux2_q, mux2_d;
  logic [2:0]                  alu_q, alu_d;
  logic                        halted_q, halted_d, illegal_q, illegal_d;
  logic [31:0]                 count_q, count_d;
  logic                        store_q, store_d;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       legal;

  assign opcode = ir_q[6:0];
  assign funct3 = ir_q[14:12];
  assign funct7 = ir_q[31:25];

  always_comb begin
    state_d   = state_q;
    im_req_d  = im_req_q;
    dm_req_d  = dm_req_q;
    dm_we_d   = dm_we_q;
    ir_d      = ir_q;
    pc_en_d   = 1'b0;
    rs1_d     = rs1_q;
    rs2_d     = rs2_q;
    rd_d      = rd_q;
    rf_we_d   = 1'b0;
    imm_d     = imm_q;
    mux1_d    = mux1_q;
    mux2_d    = mux2_q;
    alu_d     = alu_q;
    halted_d  = halted_q;
    illegal_d = illegal_q;
    count_d   = count_q;
    store_d   = store_q;
    legal     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_FETCH;
          im_req_d = 1'b1;
        end
      end
      S_FETCH: begin
        if (im_ready) begin
          ir_d     = im_rdata;
          im_req_d = 1'b0;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        rs1_d   = ir_q[19:15];
        rs2_d   = ir_q[24:20];
        rd_d    = ir_q[11:7];
        imm_d   = '0;
        mux1_d  = 1'b0;
        mux2_d  = 1'b0;
        alu_d   = 3'b000;
        store_d = 1'b0;
        if (opcode == 7'b0000011 && funct3 == 3'b010) begin
          legal  = 1'b1;
          imm_d  = sext12(ir_q[31:20]);
          mux2_d = 1'b1;
        end else if (opcode == 7'b0100011 && funct3 == 3'b010) begin
          legal   = 1'b1;
          imm_d   = sext12({ir_q[31:25], ir_q[11:7]});
          store_d = 1'b1;
        end else if (opcode == 7'b0110011 && funct3 == 3'b000 && funct7 == 7'b0000000) begin
          legal  = 1'b1;
          mux1_d = 1'b1;
        end else if (opcode == 7'b0110011 && funct3 == 3'b000 && funct7 == 7'b0100000) begin
          legal  = 1'b1;
          mux1_d = 1'b1;
          alu_d  = 3'b001;
        end else if (opcode == 7'b0010011 && funct3 == 3'b000) begin
          legal = 1'b1;
          imm_d = sext12(ir_q[31:20]);
        end
        if (legal) begin
          state_d = S_EXEC;
        end else begin
          // ecall and unsupported encodings both park here without retiring
          state_d   = S_HALT;
          halted_d  = 1'b1;
          illegal_d = (ir_q != 32'h0000_0073);
        end
      end
      S_EXEC: begin
        if (mux2_q || store_q) begin
          state_d  = S_MEM;
          dm_req_d = 1'b1;
          dm_we_d  = store_q;
        end else begin
          state_d = S_WB;
          rf_we_d = 1'b1;
          pc_en_d = 1'b1;
          count_d = count_q + 32'd1;
        end
      end
      S_MEM: begin
        if (dm_ready) begin
          dm_req_d = 1'b0;
          dm_we_d  = 1'b0;
          pc_en_d  = 1'b1;
          count_d  = count_q + 32'd1;
          if (store_q) begin
            state_d  = S_FETCH;
            im_req_d = 1'b1;
          end else begin
            state_d = S_WB;
            rf_we_d = 1'b1;
          end
        end
      end
      S_WB: begin
        state_d  = S_FETCH;
        im_req_d = 1'b1;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      im_req_q  <= 1'b0;
      dm_req_q  <= 1'b0;
      dm_we_q   <= 1'b0;
      ir_q      <= '0;
      pc_en_q   <= 1'b0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      rd_q      <= '0;
      rf_we_q   <= 1'b0;
      imm_q     <= '0;
      mux1_q    <= 1'b0;
      mux2_q    <= 1'b0;
      alu_q     <= '0;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
      count_q   <= '0;
      store_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      im_req_q  <= im_req_d;
      dm_req_q  <= dm_req_d;
      dm_we_q   <= dm_we_d;
      ir_q      <= ir_d;
      pc_en_q   <= pc_en_d;
      rs1_q     <= rs1_d;
      rs2_q     <= rs2_d;
      rd_q      <= rd_d;
      rf_we_q   <= rf_we_d;
      imm_q     <= imm_d;
      mux1_q    <= mux1_d;
      mux2_q    <= mux2_d;
      alu_q     <= alu_d;
      halted_q  <= halted_d;
      illegal_q <= illegal_d;
      count_q   <= count_d;
      store_q   <= store_d;
    end
  end

  assign im_req        = im_req_q;
  assign dm_req        = dm_req_q;
  assign dm_we         = dm_we_q;
  assign ir            = ir_q;
  assign pc_en         = pc_en_q;
  assign rf_addr_a     = rs1_q;
  assign rf_addr_b     = rs2_q;
  assign rf_write_addr = rd_q;
  assign rf_write_en   = rf_we_q;
  assign immediate     = imm_q;
  assign mux_0_sel     = 1'b0;
  assign mux_1_sel     = mux1_q;
  assign mux_2_sel     = mux2_q;
  assign alu_operation = alu_q;
  assign halted        = halted_q;
  assign illegal       = illegal_q;
  assign instr_count   = count_q;

endmodule
